data_router_seq: RTL and testbench

Sequencer for `data_router`.
- On `start` it walks one feature-map block through the router: every POY output-row group, every kernel row, every POX-wide column chunk.
- For each step it drives `bank`/`row`/`col`/`rpsel`, pulses `dw_comp`, then waits for the depthwise PE to finish (`dwpe_ena` high then low).
- It paces against the line-buffer fill (`buf_rdy`/`buf_ack`) and closes the block with `blkend`.
- Sits between the layer controller and `data_router`.

---
 rtl/data_router_seq_if.sv | 32 +++
 rtl/data_router_seq.sv | 164 ++++++++++++++++
 tb/tb_data_router_seq.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_router_seq_if.sv
// Bundle between the layer-controller side and the data_router sequencer.
// Strobes start, dw_comp, buf_ack and blkend are single-cycle pulses with no
// back-pressure. buf_rdy and dwpe_ena are levels, sampled on every rising
// clk edge, so the sequencer waits on them rather than handshaking.
interface data_router_seq_if;
    logic        start;
    logic        abort;
    logic [7:0]  cfg_bank;
    logic [7:0]  cfg_groups;
    logic [7:0]  cfg_chunks;
    logic        buf_rdy;
    logic        buf_ack;
    logic        dwpe_ena;
    logic        dw_comp;
    logic [7:0]  bank;
    logic [7:0]  row;
    logic [27:0] col;
    logic [1:0]  rpsel;
    logic        blkend;
    logic        busy;
    logic [2:0]  dbg_state;

    modport master (
        output start, abort, cfg_bank, cfg_groups, cfg_chunks, buf_rdy, dwpe_ena,
        input  buf_ack, dw_comp, bank, row, col, rpsel, blkend, busy, dbg_state
    );

    modport slave (
        input  start, abort, cfg_bank, cfg_groups, cfg_chunks, buf_rdy, dwpe_ena,
        output buf_ack, dw_comp, bank, row, col, rpsel, blkend, busy, dbg_state
    );
endinterface

// File: rtl/data_router_seq.sv
// Walks one feature-map block through data_router: row groups, kernel rows,
// column chunks. Every output is a flop; strobes and busy are decoded from
// the next state so they line up with the state they describe.
module data_router_seq #(
    parameter int POY    = 3,
    parameter int POX    = 16,
    parameter int KSIZE  = 4,
    parameter int STRIDE = 1
) (
    input logic              clk,
    input logic              rst,
    data_router_seq_if.slave io
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_WAIT_BUF = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT_HI  = 3'd4,
        S_WAIT_LO  = 3'd5,
        S_STEP     = 3'd6,
        S_END      = 3'd7
    } state_t;

    localparam logic [1:0]  KY_LAST  = 2'(KSIZE - 1);
    localparam logic [7:0]  ROW_STEP = 8'(POY * STRIDE);
    localparam logic [27:0] COL_STEP = 28'(POX * STRIDE);

    state_t      state_q, state_d;
    logic [7:0]  bank_q, groups_q, chunks_q;
    logic [7:0]  gy_q, gy_d, cx_q, cx_d;
    logic [1:0]  ky_q, ky_d;
    logic        last_cx, last_ky, last_gy, empty_cfg;
    logic        dw_comp_q, buf_ack_q, blkend_q, busy_q;
    logic        dw_comp_d, buf_ack_d, blkend_d, busy_d, addr_ld;
    logic [7:0]  row_q, row_d;
    logic [27:0] col_q, col_d;
    logic [1:0]  rpsel_q;

    assign last_cx   = (cx_q == chunks_q - 8'd1);
    assign last_ky   = (ky_q == KY_LAST);
    assign last_gy   = (gy_q == groups_q - 8'd1);
    assign empty_cfg = (groups_q == 8'd0) || (chunks_q == 8'd0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state; abort beats every other transition out of a busy state.
    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && io.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:     if (io.start && !io.abort) state_d = S_LOAD;
                S_LOAD:     state_d = empty_cfg ? S_END : S_WAIT_BUF;
                S_WAIT_BUF: if (io.buf_rdy) state_d = S_ISSUE;
                S_ISSUE:    state_d = S_WAIT_HI;
                S_WAIT_HI:  if (io.dwpe_ena) state_d = S_WAIT_LO;
                S_WAIT_LO:  if (!io.dwpe_ena) state_d = S_STEP;
                S_STEP: begin
                    if (last_cx && last_ky && last_gy) state_d = S_END;
                    else if (last_cx && last_ky)       state_d = S_WAIT_BUF;
                    else                               state_d = S_ISSUE;
                end
                S_END:      state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_comb begin
        dw_comp_d = (state_d == S_ISSUE);
        buf_ack_d = (state_d == S_STEP) && last_cx && last_ky;
        blkend_d  = (state_d == S_END);
        busy_d    = (state_d != S_IDLE);
        addr_ld   = (state_d == S_ISSUE);
        row_d     = gy_d * ROW_STEP + {6'd0, ky_d};
        col_d     = {20'd0, cx_d} * COL_STEP;
    end

    // Loop counters: cleared in LOAD, advanced cx -> ky -> gy in STEP.
    always_comb begin
        gy_d = gy_q;
        ky_d = ky_q;
        cx_d = cx_q;
        if (state_q == S_LOAD) begin
            gy_d = 8'd0;
            ky_d = 2'd0;
            cx_d = 8'd0;
        end else if (state_q == S_STEP) begin
            if (!last_cx) begin
                cx_d = cx_q + 8'd1;
            end else begin
                cx_d = 8'd0;
                if (!last_ky) begin
                    ky_d = ky_q + 2'd1;
                end else begin
                    ky_d = 2'd0;
                    gy_d = gy_q + 8'd1;
                end
            end
        end
    end

    // Counter and configuration registers; config is captured only on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gy_q     <= 8'd0;
            ky_q     <= 2'd0;
            cx_q     <= 8'd0;
            bank_q   <= 8'd0;
            groups_q <= 8'd0;
            chunks_q <= 8'd0;
        end else begin
            gy_q <= gy_d;
            ky_q <= ky_d;
            cx_q <= cx_d;
            if (state_q == S_IDLE && state_d == S_LOAD) begin
                bank_q   <= io.cfg_bank;
                groups_q <= io.cfg_groups;
                chunks_q <= io.cfg_chunks;
            end
        end
    end

    // Output flops; addresses load only when entering ISSUE, so they hold
    // through a line-buffer wait between groups.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dw_comp_q <= 1'b0;
            buf_ack_q <= 1'b0;
            blkend_q  <= 1'b0;
            busy_q    <= 1'b0;
            row_q     <= 8'd0;
            col_q     <= 28'd0;
            rpsel_q   <= 2'd0;
        end else begin
            dw_comp_q <= dw_comp_d;
            buf_ack_q <= buf_ack_d;
            blkend_q  <= blkend_d;
            busy_q    <= busy_d;
            if (addr_ld) begin
                row_q   <= row_d;
                col_q   <= col_d;
                rpsel_q <= ky_d;
            end
        end
    end

    assign io.dw_comp   = dw_comp_q;
    assign io.buf_ack   = buf_ack_q;
    assign io.blkend    = blkend_q;
    assign io.busy      = busy_q;
    assign io.bank      = bank_q;
    assign io.row       = row_q;
    assign io.col       = col_q;
    assign io.rpsel     = rpsel_q;
    assign io.dbg_state = state_q;
endmodule

// File: tb/tb_data_router_seq.sv
// Bench for data_router_seq: one STRIDE=1 and one STRIDE=2 instance run in
// lockstep on shared inputs, each with its own expected-address queue.
module tb_data_router_seq;
  localparam int POY = 3;
  localparam int POX = 16;
  localparam int KSIZE = 4;
  localparam int W = 46;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT_HI = 3'd4;
  localparam logic [2:0] ST_WAIT_LO = 3'd5;

  typedef struct {
    int groups;
    int chunks;
    logic [7:0] bank;
    int pe_len;
    int gap;
    int exp_dw;
    int exp_ack;
    int exp_blk;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned cyc = 0;

  data_router_seq_if ifa ();
  data_router_seq_if ifb ();

  data_router_seq #(.POY(POY), .POX(POX), .KSIZE(KSIZE), .STRIDE(1)) dut1 (
    .clk(clk), .rst(rst), .io(ifa)
  );
  data_router_seq #(.POY(POY), .POX(POX), .KSIZE(KSIZE), .STRIDE(2)) dut2 (
    .clk(clk), .rst(rst), .io(ifb)
  );

  assign ifb.start = ifa.start;
  assign ifb.abort = ifa.abort;
  assign ifb.cfg_bank = ifa.cfg_bank;
  assign ifb.cfg_groups = ifa.cfg_groups;
  assign ifb.cfg_chunks = ifa.cfg_chunks;
  assign ifb.buf_rdy = ifa.buf_rdy;
  assign ifb.dwpe_ena = ifa.dwpe_ena;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];
  logic [W-1:0] last_exp1 = '0;
  int chk_cnt = 0;
  int pass_cnt = 0;
  int dw_cnt = 0, ack_cnt = 0, blk_cnt = 0, gap_dw = 0, gap_bad = 0;
  int unsigned first_dw_cyc = 0, blk_cyc = 0, last_ack_cyc = 0, start_cyc = 0;
  int pe_len = 1;
  int gap_len = 0;
  int gap_arm = 0;
  int gap_seen = 0;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: address tuple sequence for one block at a given stride.
  task automatic push_block(input int g, input int c, input logic [7:0] b);
    logic [7:0] r;
    logic [27:0] cl;
    for (int gy = 0; gy < g; gy++)
      for (int ky = 0; ky < KSIZE; ky++)
        for (int cx = 0; cx < c; cx++) begin
          r = 8'((gy * POY * 1 + ky) % 256);
          cl = 28'(cx * POX * 1);
          exp_q1.push_back({b, r, cl, 2'(ky)});
          r = 8'((gy * POY * 2 + ky) % 256);
          cl = 28'(cx * POX * 2);
          exp_q2.push_back({b, r, cl, 2'(ky)});
        end
  endtask

  // Monitor, sampled on the falling edge.
  task automatic mon_sample();
    logic [W-1:0] e;
    if (!rst) begin
      if (ifa.dw_comp) begin
        dw_cnt++;
        if (dw_cnt == 1) first_dw_cyc = cyc;
        if (exp_q1.size() == 0) begin
          chk_cnt++;
          $display("FAIL sb_stride1: unexpected dw_comp row=%0d col=%0d (cycle %0d)", ifa.row, ifa.col, cyc);
        end else begin
          e = exp_q1.pop_front();
          last_exp1 = e;
          check("sb_stride1", {ifa.bank, ifa.row, ifa.col, ifa.rpsel}, e);
        end
      end
      if (ifb.dw_comp) begin
        if (exp_q2.size() == 0) begin
          chk_cnt++;
          $display("FAIL sb_stride2: unexpected dw_comp row=%0d col=%0d (cycle %0d)", ifb.row, ifb.col, cyc);
        end else begin
          e = exp_q2.pop_front();
          check("sb_stride2", {ifb.bank, ifb.row, ifb.col, ifb.rpsel}, e);
        end
      end
      if (ifa.buf_ack) begin
        ack_cnt++;
        last_ack_cyc = cyc;
      end
      if (ifa.blkend) begin
        blk_cnt++;
        blk_cyc = cyc;
      end
      if (!ifa.buf_rdy && ifa.busy) begin
        if (ifa.dw_comp) gap_dw++;
        if ({ifa.bank, ifa.row, ifa.col, ifa.rpsel} !== last_exp1) gap_bad++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    mon_sample();
  endtask

  task automatic clear_counts();
    dw_cnt = 0; ack_cnt = 0; blk_cnt = 0; gap_dw = 0; gap_bad = 0;
  endtask

  task automatic start_block(input int g, input int c, input logic [7:0] b);
    ifa.cfg_groups = 8'(g);
    ifa.cfg_chunks = 8'(c);
    ifa.cfg_bank = b;
    ifa.start = 1'b1;
    start_cyc = cyc;
    push_block(g, c, b);
    tick();
    ifa.start = 1'b0;
  endtask

  task automatic wait_blk(input int budget);
    int n = 0;
    while (blk_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check("blkend_seen", 64'(blk_cnt), 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    clear_counts();
    pe_len = v.pe_len;
    if (v.gap > 0) begin
      gap_len = v.gap;
      gap_arm++;
    end
    start_block(v.groups, v.chunks, v.bank);
    wait_blk(5000);
    tick();
    check($sformatf("v%0d_busy_drop", idx), {ifa.busy, ifb.busy, ifa.dbg_state}, {2'b00, ST_IDLE});
    repeat (2) tick();
    check($sformatf("v%0d_dw_count", idx), 64'(dw_cnt), 64'(v.exp_dw));
    check($sformatf("v%0d_ack_count", idx), 64'(ack_cnt), 64'(v.exp_ack));
    check($sformatf("v%0d_blk_count", idx), 64'(blk_cnt), 64'(v.exp_blk));
    check($sformatf("v%0d_sb_drained", idx), 64'(exp_q1.size() + exp_q2.size()), 0);
    if (v.exp_dw > 0) check($sformatf("v%0d_first_dw_lat", idx), 64'(first_dw_cyc - start_cyc), 3);
    else check($sformatf("v%0d_blkend_lat", idx), 64'(blk_cyc - start_cyc), 2);
    if (v.exp_ack > 0) check($sformatf("v%0d_ack_to_blk", idx), 64'(blk_cyc - last_ack_cyc), 1);
    if (v.gap > 0) begin
      check($sformatf("v%0d_gap_no_dw", idx), 64'(gap_dw), 0);
      check($sformatf("v%0d_gap_addr_hold", idx), 64'(gap_bad), 0);
    end
  endtask

  // PE model: raise dwpe_ena the cycle after dw_comp, hold pe_len cycles.
  initial begin
    ifa.dwpe_ena = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.dw_comp && !rst) begin
        @(negedge clk);
        ifa.dwpe_ena = 1'b1;
        repeat (pe_len) @(negedge clk);
        ifa.dwpe_ena = 1'b0;
      end
    end
  end

  // Line-buffer model: once armed, drop buf_rdy for gap_len cycles after the next buf_ack.
  initial begin
    ifa.buf_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (gap_seen != gap_arm && ifa.buf_ack && !rst) begin
        gap_seen = gap_arm;
        ifa.buf_rdy = 1'b0;
        repeat (gap_len) @(negedge clk);
        ifa.buf_rdy = 1'b1;
      end
    end
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int n;
    vecs[0] = '{groups: 2, chunks: 3, bank: 8'h11, pe_len: 4, gap: 0, exp_dw: 24, exp_ack: 2, exp_blk: 1};
    vecs[1] = '{groups: 2, chunks: 2, bank: 8'h22, pe_len: 1, gap: 0, exp_dw: 16, exp_ack: 2, exp_blk: 1};
    vecs[2] = '{groups: 2, chunks: 3, bank: 8'h33, pe_len: 2, gap: 20, exp_dw: 24, exp_ack: 2, exp_blk: 1};
    vecs[3] = '{groups: 1, chunks: 1, bank: 8'h44, pe_len: 1, gap: 0, exp_dw: 4, exp_ack: 1, exp_blk: 1};
    vecs[4] = '{groups: 0, chunks: 3, bank: 8'h45, pe_len: 1, gap: 0, exp_dw: 0, exp_ack: 0, exp_blk: 1};
    vecs[5] = '{groups: 3, chunks: 0, bank: 8'h46, pe_len: 1, gap: 0, exp_dw: 0, exp_ack: 0, exp_blk: 1};
    vecs[6] = '{groups: 3, chunks: 2, bank: 8'h55, pe_len: 3, gap: 0, exp_dw: 24, exp_ack: 3, exp_blk: 1};
    vecs[7] = '{groups: 100, chunks: 1, bank: 8'h66, pe_len: 1, gap: 0, exp_dw: 400, exp_ack: 100, exp_blk: 1};

    ifa.start = 1'b0;
    ifa.abort = 1'b0;
    ifa.cfg_bank = 8'h00;
    ifa.cfg_groups = 8'h00;
    ifa.cfg_chunks = 8'h00;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs_s1", {ifa.dw_comp, ifa.buf_ack, ifa.blkend, ifa.busy, ifa.bank, ifa.row, ifa.col, ifa.rpsel}, 0);
    check("reset_outs_s2", {ifb.dw_comp, ifb.buf_ack, ifb.blkend, ifb.busy, ifb.bank, ifb.row, ifb.col, ifb.rpsel}, 0);
    check("reset_state", {ifa.dbg_state, ifb.dbg_state}, {ST_IDLE, ST_IDLE});
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) begin
      vecs[i].pe_len = (i == 6) ? int'($urandom_range(1, 5)) : vecs[i].pe_len;
      run_vec(vecs[i], i);
    end

    // start pulsed mid-block with a different config must be ignored
    clear_counts();
    pe_len = 1;
    start_block(2, 3, 8'h5A);
    repeat (10) tick();
    ifa.cfg_groups = 8'd1;
    ifa.cfg_chunks = 8'd1;
    ifa.cfg_bank = 8'hA5;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    wait_blk(5000);
    repeat (2) tick();
    check("busy_start_dw_count", 64'(dw_cnt), 24);
    check("busy_start_ack_count", 64'(ack_cnt), 2);
    check("busy_start_sb_drained", 64'(exp_q1.size() + exp_q2.size()), 0);

    // abort in WAIT_HI of step 5
    clear_counts();
    pe_len = 2;
    start_block(2, 3, 8'h3C);
    n = 0;
    while (dw_cnt < 5 && n < 500) begin
      tick();
      n++;
    end
    check("abort_reach_step5", 64'(dw_cnt), 5);
    tick();
    check("abort_in_wait_hi", 64'(ifa.dbg_state), 64'(ST_WAIT_HI));
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    check("abort_to_idle", {ifa.dbg_state, ifb.dbg_state, ifa.busy, ifb.busy}, {ST_IDLE, ST_IDLE, 2'b00});
    exp_q1.delete();
    exp_q2.delete();
    repeat (12) tick();
    check("abort_no_blkend", 64'(blk_cnt), 0);
    check("abort_no_more_dw", 64'(dw_cnt), 5);

    // zero-group block after abort: blkend two cycles after start
    clear_counts();
    start_block(0, 3, 8'h01);
    wait_blk(50);
    check("zero_grp_blkend_lat", 64'(blk_cyc - start_cyc), 2);
    repeat (2) tick();
    check("zero_grp_no_dw", 64'(dw_cnt), 0);

    // start and abort together while idle: stays idle
    clear_counts();
    ifa.cfg_groups = 8'd1;
    ifa.cfg_chunks = 8'd1;
    ifa.start = 1'b1;
    ifa.abort = 1'b1;
    tick();
    ifa.start = 1'b0;
    ifa.abort = 1'b0;
    check("start_abort_idle", {ifa.dbg_state, ifa.busy}, {ST_IDLE, 1'b0});
    repeat (6) tick();
    check("start_abort_no_dw", 64'(dw_cnt), 0);

    // asynchronous reset while in WAIT_LO
    clear_counts();
    pe_len = 3;
    start_block(2, 3, 8'h99);
    n = 0;
    while (ifa.dbg_state != ST_WAIT_LO && n < 200) begin
      tick();
      n++;
    end
    check("rst_reach_wait_lo", 64'(ifa.dbg_state), 64'(ST_WAIT_LO));
    rst = 1'b1;
    #1;
    check("rst_mid_outs_s1", {ifa.dw_comp, ifa.buf_ack, ifa.blkend, ifa.busy, ifa.bank, ifa.row, ifa.col, ifa.rpsel}, 0);
    check("rst_mid_outs_s2", {ifb.dw_comp, ifb.buf_ack, ifb.blkend, ifb.busy, ifb.bank, ifb.row, ifb.col, ifb.rpsel}, 0);
    exp_q1.delete();
    exp_q2.delete();
    repeat (2) tick();
    rst = 1'b0;
    repeat (6) tick();
    clear_counts();
    pe_len = 1;
    start_block(1, 1, 8'h77);
    wait_blk(200);
    repeat (2) tick();
    check("rst_restart_dw_count", 64'(dw_cnt), 4);
    check("rst_restart_sb_drained", 64'(exp_q1.size() + exp_q2.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
